// File: rtl/altr_hps_sb_pkg.sv
// Shared definitions for the HPS sideband serial link (transmitter and receiver).
package altr_hps_sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } sb_state_e;

  localparam logic SB_IDLE_LVL  = 1'b1;
  localparam logic SB_START_LVL = 1'b0;

  // Bits needed to hold max_val, never narrower than one bit.
  function automatic int sb_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/altr_hps_sb_tick.sv
// Bit-time tick counter: bit_end flags the last clk of each CLKS_PER_BIT-long bit-time.
module altr_hps_sb_tick
  import altr_hps_sb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int TW = sb_cnt_w(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick;

  assign bit_end = (tick == TICK_LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (restart || bit_end) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/altr_hps_sb_ser.sv
// Sideband serializer: accepts a word on valid/ready and sends start, data (LSB first),
// optional even parity, stop and optional idle-gap bits on a registered sb_out.
module altr_hps_sb_ser
  import altr_hps_sb_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int IDLE_GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sb_out,
  output logic              busy
);

  localparam int BIT_LAST = DATA_W - 1;
  localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam int CNT_MAX  = (BIT_LAST > GAP_LAST) ? BIT_LAST : GAP_LAST;
  localparam int BW       = sb_cnt_w(CNT_MAX);

  sb_state_e         state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic              bit_last;
  logic              parity_q;
  logic              line_lvl;
  logic              bit_end;
  logic              accept;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid && tx_ready;

  // The bit counter serves the data bits and, reused, the idle-gap bit-times.
  assign bit_last = (state == ST_GAP) ? (bit_cnt == BW'(GAP_LAST))
                                      : (bit_cnt == BW'(BIT_LAST));

  altr_hps_sb_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state == ST_IDLE),
    .bit_end(bit_end)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    line_lvl  = SB_IDLE_LVL;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_START;
      end
      ST_START: begin
        line_lvl = SB_START_LVL;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        line_lvl = shift[0];
        if (bit_end && bit_last) state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_lvl = parity_q;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_nxt = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (bit_end && bit_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      parity_q <= 1'b0;
    end else if (accept) begin
      shift    <= tx_data;
      parity_q <= ^tx_data;
    end else if ((state == ST_DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (bit_end && ((state == ST_DATA) || (state == ST_GAP))) begin
      bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
    end
  end

  // Registered line: sb_out follows the state level one clk later, so the start bit
  // appears on the edge after the accept edge and the line is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_out <= SB_IDLE_LVL;
    end else begin
      sb_out <= line_lvl;
    end
  end

endmodule

// File: tb/tb_altr_hps_sb_ser.sv
// Bench for altr_hps_sb_ser: three parameter sets checked cycle by cycle against a
// frame model built from start/data/parity/stop/gap rules.
module tb_altr_hps_sb_ser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid;
  logic [7:0] data [3];
  logic [2:0] sb, ready, busy;

  int errors = 0;
  int checks = 0;

  int cfg_dw  [3] = '{8, 8, 5};
  int cfg_cpb [3] = '{2, 3, 1};
  int cfg_par [3] = '{1, 0, 1};
  int cfg_gap [3] = '{0, 2, 1};

  bit exp_q [$];

  always #5 clk = ~clk;

  altr_hps_sb_ser #(.DATA_W(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .sb_out(sb[0]), .busy(busy[0]));

  altr_hps_sb_ser #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_EN(0), .IDLE_GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .sb_out(sb[1]), .busy(busy[1]));

  altr_hps_sb_ser #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(1), .IDLE_GAP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][4:0]),
    .tx_ready(ready[2]), .sb_out(sb[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line waveform of one frame, one entry per clk, starting with the start bit.
  task automatic build(input int k, input logic [7:0] d);
    int ones;
    ones = 0;
    exp_q.delete();
    repeat (cfg_cpb[k]) exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_dw[k]; i++) begin
      ones += int'(d[i]);
      repeat (cfg_cpb[k]) exp_q.push_back(d[i]);
    end
    if (cfg_par[k] != 0) repeat (cfg_cpb[k]) exp_q.push_back(bit'(ones % 2));
    repeat (cfg_cpb[k]) exp_q.push_back(1'b1);
    repeat (cfg_gap[k] * cfg_cpb[k]) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_wait_ready", k), ready[k], 1'b1);
  endtask

  // Sends one word and checks every line clk; disturb_at >= 0 pokes tx_valid/tx_data
  // at that line clk while the frame is in flight.
  task automatic send(input int k, input logic [7:0] d, input int disturb_at);
    int n;
    wait_ready(k);
    build(k, d);
    n = exp_q.size();
    data[k]  = d;
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
    @(negedge clk);
    check($sformatf("dut%0d_latency_sb", k), sb[k], 1'b1);
    check($sformatf("dut%0d_busy", k), busy[k], 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("dut%0d_d%02h_bit%0d", k, d, i), sb[k], exp_q[i]);
      check($sformatf("dut%0d_d%02h_ready%0d", k, d, i), ready[k], (i == n - 1));
      if (i == disturb_at) begin
        data[k]  = 8'($urandom);
        valid[k] = 1'b1;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
      end
    end
    repeat (2) begin
      @(negedge clk);
      check($sformatf("dut%0d_post_sb", k), sb[k], 1'b1);
      check($sformatf("dut%0d_post_busy", k), busy[k], 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         all_q [$];
    bit         seen;
    logic [7:0] w;
    int         n1;

    // Reset with tx_valid held high: no frame may start.
    rst_n = 1'b0;
    valid = 3'b111;
    for (int k = 0; k < 3; k++) data[k] = 8'($urandom);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_sb%0d", k), sb[k], 1'b1);
      check($sformatf("rst_ready%0d", k), ready[k], 1'b1);
      check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
    end
    valid = 3'b000;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) check($sformatf("post_rst_sb%0d", k), sb[k], 1'b1);
    end

    // Basic frame and gap/no-parity frame.
    send(0, 8'hA5, -1);
    send(1, 8'hFF, -1);

    // Back-to-back with tx_valid held: exactly one idle clk between frames.
    wait_ready(0);
    build(0, 8'h01);
    n1 = exp_q.size();
    all_q = {1'b1};
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    all_q.push_back(1'b1);
    build(0, 8'h80);
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    data[0]  = 8'h01;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    data[0] = 8'h80;
    seen    = 1'b0;
    for (int i = 0; i < all_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("b2b_bit%0d", i), sb[0], all_q[i]);
      if (ready[0] && !seen) begin
        check_int("b2b_accept_cycle", i, n1);
        seen = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        data[0]  = 8'($urandom);
      end
    end
    check("b2b_second_accepted", seen, 1'b1);
    @(negedge clk);
    check("b2b_end_ready", ready[0], 1'b1);
    check("b2b_end_sb", sb[0], 1'b1);

    // Mid-frame reset during data bit 3 (chosen as a 0 so the forced 1 is visible).
    wait_ready(0);
    w = 8'($urandom) & 8'hF7;
    build(0, w);
    data[0]  = w;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("mid_bit%0d", i), sb[0], (i == 0) ? 1'b1 : exp_q[i-1]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sb", sb[0], 1'b1);
    check("mid_rst_ready", ready[0], 1'b1);
    check("mid_rst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", ready[0], 1'b1);
    check("mid_rel_sb", sb[0], 1'b1);
    send(0, 8'h3C, -1);

    // Randomized words on every configuration, half with a mid-frame poke.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++) send(k, 8'($urandom), (it % 2 == 1) ? 3 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
